// File: rtl/multiply_stream.sv
`default_nettype none
// ============================================================================
// Module   : multiply_stream
// Brief    : Two-stage pipelined fixed-point multiplier between FWFT FIFOs,
//            with rounding, saturation, square mode and stall-safe flow control.
// Revision : 1.0 - initial release
// ============================================================================
module multiply_stream #(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = 10,
  parameter int ROUND     = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 x_in_empty,
  input  logic                 y_in_empty,
  output logic                 x_in_rd_en,
  output logic                 y_in_rd_en,
  input  logic [DATA_SIZE-1:0] x,
  input  logic [DATA_SIZE-1:0] y,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 sat,
  output logic [31:0]          out_count
);

  localparam int c_pw = 2 * DATA_SIZE;
  localparam int c_rw = c_pw + 1;
  localparam logic [c_rw-1:0] c_half =
    (ROUND != 0) ? (c_rw'(1) << (FRAC_BITS - 1)) : {c_rw{1'b0}};
  localparam logic [DATA_SIZE-1:0] c_max = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] c_min = {1'b1, {(DATA_SIZE-1){1'b0}}};

  logic                   r_s1_valid;
  logic signed [c_pw-1:0] r_s1_prod;
  logic                   r_s2_valid;
  logic [DATA_SIZE-1:0]   r_dout;
  logic                   r_sat;
  logic [31:0]            r_out_count;

  logic w_s2_fire, w_s1_adv, w_s1_free, w_avail, w_consume;

  assign w_s2_fire = r_s2_valid & ~out_full;
  assign w_s1_adv  = r_s1_valid & (~r_s2_valid | w_s2_fire);
  assign w_s1_free = ~r_s1_valid | w_s1_adv;
  assign w_avail   = ~x_in_empty & (mode | ~y_in_empty);
  assign w_consume = w_avail & w_s1_free & ~reset;

  // Reset suppresses every handshake so nothing is popped or pushed while flushing.
  assign x_in_rd_en = w_consume;
  assign y_in_rd_en = w_consume & ~mode;
  assign out_wr_en  = w_s2_fire & ~reset;
  assign dout       = r_dout;
  assign sat        = r_sat;
  assign out_count  = r_out_count;

  logic [DATA_SIZE-1:0]   w_op_b;
  logic signed [c_pw-1:0] w_xe;
  logic signed [c_pw-1:0] w_be;
  logic signed [c_pw-1:0] w_prod;

  assign w_op_b = mode ? x : y;
  assign w_xe   = {{DATA_SIZE{x[DATA_SIZE-1]}}, x};
  assign w_be   = {{DATA_SIZE{w_op_b[DATA_SIZE-1]}}, w_op_b};
  assign w_prod = w_xe * w_be;

  // Magnitude carries one extra bit so negating the most-negative product is safe.
  logic                 w_neg;
  logic [c_rw-1:0]      w_pext;
  logic [c_rw-1:0]      w_abs;
  logic [c_rw-1:0]      w_mag;
  logic [c_rw-1:0]      w_r;
  logic                 w_fits;
  logic [DATA_SIZE-1:0] w_dq;
  logic                 w_dq_sat;

  assign w_neg  = r_s1_prod[c_pw-1];
  assign w_pext = {r_s1_prod[c_pw-1], r_s1_prod};
  assign w_abs  = w_neg ? -w_pext : w_pext;
  assign w_mag  = (w_abs + c_half) >> FRAC_BITS;
  assign w_r    = w_neg ? -w_mag : w_mag;
  assign w_fits = (&w_r[c_rw-1:DATA_SIZE-1]) | ~(|w_r[c_rw-1:DATA_SIZE-1]);

  always_comb begin
    w_dq     = w_r[DATA_SIZE-1:0];
    w_dq_sat = 1'b0;
    if ((SATURATE != 0) && !w_fits) begin
      w_dq_sat = 1'b1;
      w_dq     = w_r[c_rw-1] ? c_min : c_max;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_prod   <= '0;
      r_s2_valid  <= 1'b0;
      r_dout      <= '0;
      r_sat       <= 1'b0;
      r_out_count <= '0;
    end else begin
      if (w_consume) begin
        r_s1_valid <= 1'b1;
        r_s1_prod  <= w_prod;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_dout     <= w_dq;
        r_sat      <= w_dq_sat;
      end else if (w_s2_fire) begin
        r_s2_valid <= 1'b0;
      end

      if (w_s2_fire) begin
        r_out_count <= r_out_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiply_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiply_stream
// Brief    : Directed self-checking bench; three instances share one stimulus
//            (truncate+saturate, round+saturate, truncate+wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiply_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        x_in_empty = 1'b1;
  logic        y_in_empty = 1'b1;
  logic        out_full = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;

  logic        x_rd_a, y_rd_a, wr_a, sat_a;
  logic        x_rd_r, y_rd_r, wr_r, sat_r;
  logic        x_rd_w, y_rd_w, wr_w, sat_w;
  logic [31:0] dout_a, dout_r, dout_w;
  logic [31:0] cnt_a, cnt_r, cnt_w;

  always #5 clock = ~clock;

  multiply_stream #(.DATA_SIZE(32), .FRAC_BITS(10), .ROUND(0), .SATURATE(1)) u_dut (
    .clock(clock), .reset(reset), .mode(mode),
    .x_in_empty(x_in_empty), .y_in_empty(y_in_empty),
    .x_in_rd_en(x_rd_a), .y_in_rd_en(y_rd_a), .x(x), .y(y),
    .out_full(out_full), .out_wr_en(wr_a), .dout(dout_a), .sat(sat_a), .out_count(cnt_a)
  );

  multiply_stream #(.DATA_SIZE(32), .FRAC_BITS(10), .ROUND(1), .SATURATE(1)) u_rnd (
    .clock(clock), .reset(reset), .mode(mode),
    .x_in_empty(x_in_empty), .y_in_empty(y_in_empty),
    .x_in_rd_en(x_rd_r), .y_in_rd_en(y_rd_r), .x(x), .y(y),
    .out_full(out_full), .out_wr_en(wr_r), .dout(dout_r), .sat(sat_r), .out_count(cnt_r)
  );

  multiply_stream #(.DATA_SIZE(32), .FRAC_BITS(10), .ROUND(0), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .mode(mode),
    .x_in_empty(x_in_empty), .y_in_empty(y_in_empty),
    .x_in_rd_en(x_rd_w), .y_in_rd_en(y_rd_w), .x(x), .y(y),
    .out_full(out_full), .out_wr_en(wr_w), .dout(dout_w), .sat(sat_w), .out_count(cnt_w)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] xq[$];
  logic [31:0] yq[$];
  logic [31:0] oa[$];
  logic [31:0] orr[$];
  logic [31:0] ow[$];
  logic        sa[$];
  logic        sr[$];
  logic        sw[$];
  int          wc[$];
  logic        l_xr, l_yr, l_wr;
  logic        y_seen;

  task automatic drive();
    x_in_empty = (xq.size() == 0);
    y_in_empty = (yq.size() == 0);
    x = x_in_empty ? 32'd0 : xq[0];
    y = y_in_empty ? 32'd0 : yq[0];
  endtask

  // Sample at the falling edge, apply FIFO pops just after the rising edge.
  task automatic step();
    @(negedge clock);
    l_xr = x_rd_a;
    l_yr = y_rd_a;
    l_wr = wr_a;
    if (l_yr) y_seen = 1'b1;
    if (l_wr) begin
      oa.push_back(dout_a);  sa.push_back(sat_a);
      orr.push_back(dout_r); sr.push_back(sat_r);
      ow.push_back(dout_w);  sw.push_back(sat_w);
      wc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (l_xr && xq.size() != 0) void'(xq.pop_front());
    if (l_yr && yq.size() != 0) void'(yq.pop_front());
    drive();
  endtask

  task automatic clear_out();
    oa.delete(); orr.delete(); ow.delete();
    sa.delete(); sr.delete(); sw.delete();
    wc.delete();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic use_y);
    xq.push_back(a);
    if (use_y) yq.push_back(b);
    drive();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++;
    if (l_xr !== 1'b0 || l_wr !== 1'b0) begin
      n_err++; $display("FAIL reset_handshake: rd=%b wr=%b required 0 0", l_xr, l_wr);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (cnt_a !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d required 0", cnt_a);
    end
    n_vec++;
    if (dout_a !== 32'd0 || sat_a !== 1'b0) begin
      n_err++; $display("FAIL reset_dout_sat: got %h/%b required 0/0", dout_a, sat_a);
    end
    n_vec++;
    if (wr_a !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_en: got %b required 0", wr_a);
    end
  endtask

  task automatic test_basic();
    int c0;
    clear_out();
    c0 = cyc;
    push(32'd1024, 32'd3072, 1'b1);
    push(32'hFFFFFA00, 32'd1024, 1'b1);
    repeat (6) step();
    n_vec++;
    if (oa.size() != 2) begin
      n_err++; $display("FAIL basic_count: got %0d results required 2", oa.size());
    end else begin
      n_vec++;
      if (oa[0] !== 32'd3072 || sa[0] !== 1'b0) begin
        n_err++; $display("FAIL basic_p0: got %h/%b required 00000c00/0", oa[0], sa[0]);
      end
      n_vec++;
      if (oa[1] !== 32'hFFFFFA00 || orr[1] !== 32'hFFFFFA00 || ow[1] !== 32'hFFFFFA00) begin
        n_err++; $display("FAIL basic_p1: got %h %h %h required fffffa00", oa[1], orr[1], ow[1]);
      end
      n_vec++;
      if (wc[0] != c0 + 2 || wc[1] != c0 + 3) begin
        n_err++; $display("FAIL basic_latency: got %0d,%0d required %0d,%0d",
                          wc[0] - c0, wc[1] - c0, 2, 3);
      end
    end
    n_vec++;
    if (cnt_a !== 32'd2) begin
      n_err++; $display("FAIL basic_out_count: got %0d required 2", cnt_a);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] xs[4] = '{32'd3, 32'hFFFFFFFD, 32'd512, 32'hFFFFFE00};
    logic [31:0] et[4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] er[4] = '{32'd0, 32'd0, 32'd1, 32'hFFFFFFFF};
    clear_out();
    for (int i = 0; i < 4; i++) push(xs[i], 32'd1, 1'b1);
    repeat (8) step();
    n_vec++;
    if (oa.size() != 4) begin
      n_err++; $display("FAIL round_count: got %0d results required 4", oa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (oa[i] !== et[i] || orr[i] !== er[i]) begin
          n_err++; $display("FAIL round_%0d: trunc %h round %h required %h %h",
                            i, oa[i], orr[i], et[i], er[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    clear_out();
    push(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    push(32'h80000000, 32'h7FFFFFFF, 1'b1);
    repeat (6) step();
    n_vec++;
    if (oa.size() != 2) begin
      n_err++; $display("FAIL sat_count: got %0d results required 2", oa.size());
    end else begin
      n_vec++;
      if (oa[0] !== 32'h7FFFFFFF || sa[0] !== 1'b1 || orr[0] !== 32'h7FFFFFFF || sr[0] !== 1'b1) begin
        n_err++; $display("FAIL sat_max: got %h/%b %h/%b required 7fffffff/1", oa[0], sa[0], orr[0], sr[0]);
      end
      n_vec++;
      if (oa[1] !== 32'h80000000 || sa[1] !== 1'b1) begin
        n_err++; $display("FAIL sat_min: got %h/%b required 80000000/1", oa[1], sa[1]);
      end
      n_vec++;
      if (ow[0] !== 32'hFFC00000 || sw[0] !== 1'b0 || ow[1] !== 32'h00200000 || sw[1] !== 1'b0) begin
        n_err++; $display("FAIL sat_wrap: got %h/%b %h/%b required ffc00000/0 00200000/0",
                          ow[0], sw[0], ow[1], sw[1]);
      end
    end
  endtask

  task automatic test_square();
    clear_out();
    y_seen = 1'b0;
    mode = 1'b1;
    push(32'd2048, 32'd0, 1'b0);
    push(32'hFFFFFC00, 32'd0, 1'b0);
    repeat (6) step();
    mode = 1'b0;
    n_vec++;
    if (oa.size() != 2) begin
      n_err++; $display("FAIL square_count: got %0d results required 2", oa.size());
    end else begin
      n_vec++;
      if (oa[0] !== 32'd4096 || oa[1] !== 32'd1024) begin
        n_err++; $display("FAIL square_vals: got %0d %0d required 4096 1024", oa[0], oa[1]);
      end
    end
    n_vec++;
    if (y_seen !== 1'b0) begin
      n_err++; $display("FAIL square_y_rd: got y_in_rd_en=1 required never asserted");
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int viol;
    int bad_flight;
    apply_reset();
    clear_out();
    viol = 0;
    bad_flight = 0;
    for (int k = 0; k < 8; k++) push(32'((k + 1) * 1024), 32'd2048, 1'b1);
    c0 = cyc;
    for (int i = 0; i < 18; i++) begin
      out_full = (i >= 3 && i <= 7);
      step();
      if (i >= 3 && i <= 7) begin
        if (l_xr || l_yr || l_wr) viol++;
        if (8 - xq.size() - oa.size() != 2) bad_flight++;
      end
    end
    out_full = 1'b0;
    n_vec++;
    if (viol != 0) begin
      n_err++; $display("FAIL bp_enables_while_full: got %0d cycles active required 0", viol);
    end
    n_vec++;
    if (bad_flight != 0) begin
      n_err++; $display("FAIL bp_in_flight: got %0d cycles not 2 in flight required 0", bad_flight);
    end
    n_vec++;
    if (oa.size() != 8) begin
      n_err++; $display("FAIL bp_count: got %0d results required 8", oa.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (oa[k] !== 32'((k + 1) * 2048) || wc[k] != (k == 0 ? c0 + 2 : c0 + 7 + k)) begin
          n_err++; $display("FAIL bp_result_%0d: got %0d at cycle %0d required %0d at cycle %0d",
                            k, oa[k], wc[k] - c0, (k + 1) * 2048, (k == 0 ? 2 : 7 + k));
        end
      end
    end
    n_vec++;
    if (cnt_a !== 32'd8) begin
      n_err++; $display("FAIL bp_out_count: got %0d required 8", cnt_a);
    end
  endtask

  task automatic test_reset_midstream();
    int c0;
    clear_out();
    for (int k = 0; k < 4; k++) push(32'((k + 1) * 1024), 32'd1024, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    n_vec++;
    if (l_xr !== 1'b0 || l_yr !== 1'b0 || l_wr !== 1'b0) begin
      n_err++; $display("FAIL midreset_enables: got rd=%b/%b wr=%b required 0", l_xr, l_yr, l_wr);
    end
    reset = 1'b0;
    xq.delete();
    yq.delete();
    drive();
    clear_out();
    repeat (3) step();
    n_vec++;
    if (oa.size() != 0 || cnt_a !== 32'd0) begin
      n_err++; $display("FAIL midreset_flush: got %0d writes count %0d required 0 0", oa.size(), cnt_a);
    end
    push(32'd1024, 32'd5120, 1'b1);
    c0 = cyc;
    repeat (4) step();
    n_vec++;
    if (oa.size() != 1 || oa[0] !== 32'd5120 || wc[0] != c0 + 2) begin
      n_err++; $display("FAIL midreset_next: got %0d writes first %0d required 1 write of 5120 at +2",
                        oa.size(), (oa.size() != 0) ? oa[0] : 32'd0);
    end
    n_vec++;
    if (cnt_a !== 32'd1) begin
      n_err++; $display("FAIL midreset_count: got %0d required 1", cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_square();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiply_stream.md
Name: multiply_stream

Overview:
- Parametrised, fully pipelined fixed-point multiplier between FIFOs: consumes one x/y operand pair per cycle and writes one dequantised product per cycle to an output FIFO.
- Generalises the existing two-state READ/WRITE multiplier with configurable width, fraction bits, rounding, saturation, a square mode, and stall-safe back-pressure.
- Used on the FM-radio datapath wherever sample-by-sample products are needed: demodulation, gain and squaring.

Parameters:
- DATA_SIZE, 32, operand and result width (signed two's complement).
- FRAC_BITS, 10, fixed-point fraction bits; product is scaled by 2^-FRAC_BITS. Must satisfy 1 <= FRAC_BITS < DATA_SIZE.
- ROUND, 0, 0 = truncate toward zero; 1 = round half away from zero.
- SATURATE, 1, 1 = clamp to the signed DATA_SIZE range; 0 = keep the low DATA_SIZE bits (wrap).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = x*y; 1 = x*x (y FIFO untouched).
- x_in_empty  in  1  x FIFO empty.
- y_in_empty  in  1  y FIFO empty.
- x_in_rd_en  out  1  pop x (first-word-fall-through; x is valid while not empty).
- y_in_rd_en  out  1  pop y.
- x  in  DATA_SIZE  signed x operand.
- y  in  DATA_SIZE  signed y operand.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  push dout.
- dout  out  DATA_SIZE  signed result.
- sat  out  1  high with out_wr_en when that result was clamped.
- out_count  out  32  results written since reset; wraps at 2^32.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high, sampled on the rising edge of clock. Reset clears s1_valid, s2_valid, dout, sat and out_count to 0. Reset dominates all other events, including mid-stream: in-flight data is discarded, and no rd_en or wr_en is asserted in the reset cycle.
- Pipeline stages: S1 holds the full 2*DATA_SIZE signed product; S2 holds the dequantised, saturated result and its sat flag.
- Handshake signals, all combinational:
  - s2_fire = s2_valid & ~out_full
  - s1_adv = s1_valid & (~s2_valid | s2_fire)
  - s1_free = ~s1_valid | s1_adv
  - avail = ~x_in_empty & (mode | ~y_in_empty)
  - consume = avail & s1_free
- Read enables: x_in_rd_en = consume. y_in_rd_en = consume & ~mode. The y FIFO is never popped without x, and vice versa in mode 0.
- Write enable: out_wr_en = s2_fire. dout and sat are registered (S2 contents) and hold their value while stalled.
- S1 load: on consume, product <= x*y (mode 0) or x*x (mode 1). mode is sampled per element on the consume cycle, so mode changes mid-stream take effect for the next element consumed.
- S2 load: on s1_adv, S2 loads from S1. S2 valid clears on s2_fire with no s1_adv in the same cycle.
- Latency: operands consumed at edge t appear on dout with out_wr_en asserted from cycle t+2 when out_full=0.
- Throughput: 1 result per cycle with no bubbles. Simultaneous consume, s1_adv and s2_fire in one cycle is the normal streaming case.
- Stall: with out_full held high, S2 then S1 fill, after which rd_en stays low. No element is dropped or duplicated, and order is preserved. When out_full falls, output resumes the same cycle.
- Dequantise (on S1 -> S2):
  - ROUND=0: r = sign(p) * (|p| >> FRAC_BITS).
  - ROUND=1: r = sign(p) * ((|p| + 2^(FRAC_BITS-1)) >> FRAC_BITS).
  - |p| is computed at 2*DATA_SIZE+1 bits so the most-negative product does not overflow.
- Saturate:
  - SATURATE=1: r > 2^(DATA_SIZE-1)-1 yields the max value with sat=1; r < -2^(DATA_SIZE-1) yields the min value with sat=1; otherwise sat=0.
  - SATURATE=0: dout = r[DATA_SIZE-1:0] and sat is always 0.
- out_count increments on every s2_fire.

Test Plan (DATA_SIZE=32, FRAC_BITS=10 unless noted):
- Basic product: x=1024 (1.0), y=3072 (3.0), mode=0 -> dout=3072 at t+2, sat=0, out_count=1. x=-1536, y=1024 -> dout=-1536.
- Rounding: x=3, y=1 and x=-3, y=1 with ROUND=0 -> 0 and 0 (toward zero, not -1). x=512, y=1 with ROUND=1 -> 1; x=-512, y=1 -> -1.
- Saturation: x=y=0x7FFFFFFF, SATURATE=1 -> dout=0x7FFFFFFF, sat=1. x=0x80000000, y=0x7FFFFFFF -> dout=0x80000000, sat=1. With SATURATE=0 -> low 32 bits of the shifted product, sat=0.
- Square mode: mode=1, x FIFO holds {2048, -1024}, y FIFO empty -> outputs {4096, 1024}; y_in_rd_en never asserts.
- Back-pressure and streaming: 8 pairs preloaded, out_full high for cycles 3-7 -> exactly 2 elements held in flight; rd_en low while full; all 8 results emitted in order; out_count=8; one result per cycle when unstalled.
- Reset mid-stream: reset asserted for one cycle while S1 and S2 are valid -> no out_wr_en after reset until new input arrives; out_count=0; next pair appears at t+2.
